// File: rtl/inning_scoreboard.sv
// inning_scoreboard: baseball game-state tracker driven by one-hot at-bat results
module inning_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hitout,
  input  logic       hit_valid,
  output logic       ready,
  output logic [2:0] bases,
  output logic [1:0] outs,
  output logic [3:0] inning,
  output logic       top_half,
  output logic [6:0] score_away,
  output logic [6:0] score_home,
  output logic       bad_event,
  output logic       game_over
);
  typedef enum logic [1:0] {PLAY, CHANGE, OVER} state_t;
  state_t     state_q, state_d;
  logic [2:0] bases_q, bases_d;
  logic [1:0] outs_q, outs_d;
  logic [3:0] inning_q, inning_d;
  logic       top_q, top_d;
  logic [6:0] away_q, away_d, home_q, home_d;
  logic       bad_q, bad_d;
  logic       one_hot, end_game;
  logic [2:0] k, runs;
  logic [7:0] adv, away_sum, home_sum;
  logic [6:0] away_sat, home_sat;
  // next-state: runner advance, scoring, outs, half-inning change and game-over decision
  always_comb begin
    state_d  = state_q;
    bases_d  = bases_q;
    outs_d   = outs_q;
    inning_d = inning_q;
    top_d    = top_q;
    away_d   = away_q;
    home_d   = home_q;
    bad_d    = 1'b0;
    one_hot  = (hitout != 5'd0) && ((hitout & (hitout - 5'd1)) == 5'd0);
    k        = hitout[4] ? 3'd1 : hitout[3] ? 3'd2 : hitout[2] ? 3'd3 : 3'd4;
    adv      = {4'b0, bases_q, 1'b1} << k;
    runs     = {2'b0, adv[7]} + {2'b0, adv[6]} + {2'b0, adv[5]} + {2'b0, adv[4]};
    away_sum = {1'b0, away_q} + {5'b0, runs};
    home_sum = {1'b0, home_q} + {5'b0, runs};
    away_sat = (away_sum > 8'd99) ? 7'd99 : away_sum[6:0];
    home_sat = (home_sum > 8'd99) ? 7'd99 : home_sum[6:0];
    end_game = top_q ? (inning_q >= 4'd9 && home_q > away_q)
                     : ((inning_q >= 4'd9 && home_q != away_q) || inning_q == 4'd12);
    case (state_q)
      PLAY: begin
        if (hit_valid) begin
          if (!one_hot) begin
            bad_d = 1'b1;
          end else if (hitout[0]) begin
            outs_d  = outs_q + 2'd1;
            state_d = (outs_q == 2'd2) ? CHANGE : PLAY;
          end else begin
            bases_d = adv[3:1];
            away_d  = top_q ? away_sat : away_q;
            home_d  = top_q ? home_q : home_sat;
            state_d = (!top_q && inning_q >= 4'd9 && home_sat > away_q) ? OVER : PLAY;
          end
        end
      end
      CHANGE: begin
        bases_d  = 3'd0;
        outs_d   = 2'd0;
        state_d  = end_game ? OVER : PLAY;
        top_d    = end_game ? top_q : !top_q;
        inning_d = (!end_game && !top_q) ? inning_q + 4'd1 : inning_q;
      end
      default: ;
    endcase
  end
  // state registers with synchronous reset to the start of the game
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      bases_q  <= 3'd0;
      outs_q   <= 2'd0;
      inning_q <= 4'd1;
      top_q    <= 1'b1;
      away_q   <= 7'd0;
      home_q   <= 7'd0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bases_q  <= bases_d;
      outs_q   <= outs_d;
      inning_q <= inning_d;
      top_q    <= top_d;
      away_q   <= away_d;
      home_q   <= home_d;
      bad_q    <= bad_d;
    end
  end
  assign ready      = (state_q == PLAY);
  assign game_over  = (state_q == OVER);
  assign bases      = bases_q;
  assign outs       = outs_q;
  assign inning     = inning_q;
  assign top_half   = top_q;
  assign score_away = away_q;
  assign score_home = home_q;
  assign bad_event  = bad_q;
endmodule
